// File: rtl/microwave_pkg.sv
// Shared types and helpers for the microwave cook sequencer.
// The state encoding doubles as the one-hot {DONE,PAUSE,RUN,IDLE} LED pattern.
package microwave_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        RUN   = 4'b0010,
        PAUSE = 4'b0100,
        DONE  = 4'b1000
    } state_e;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_MODE,
        EV_ADD,
        EV_START,
        EV_CLR,
        EV_DOOR
    } event_e;

    // Lowest to highest priority; index i matches bit i of the request vector.
    localparam event_e BTN_PRIO [5] = '{EV_MODE, EV_ADD, EV_START, EV_CLR, EV_DOOR};

    // req = {door, clr, start, add, mode}; the highest-priority active request wins.
    function automatic event_e pick_event(input logic [4:0] req);
        event_e ev;
        ev = EV_NONE;
        for (int i = 0; i < 5; i++)
            if (req[i]) ev = BTN_PRIO[i];
        return ev;
    endfunction

    function automatic int unsigned duty_of(input int unsigned period,
                                            input int unsigned n_modes,
                                            input int unsigned m);
        return (period * (m + 1)) / n_modes;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM: output high while the counter is below duty and en is set.
// Duty may change at any time; it applies at the next compare.
module pwm_gen #(
    parameter int unsigned PWM_PERIOD = 1000,
    localparam int unsigned DUTY_W    = $clog2(PWM_PERIOD + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm
);

    logic [DUTY_W-1:0] cnt_q;
    logic              pwm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= (cnt_q == DUTY_W'(PWM_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
            pwm_q <= en && (cnt_q < duty);
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/microwave_cook_ctrl.sv
// Microwave cook sequencer: time entry, run/pause/done FSM, 1 s prescaler,
// power-mode selection and heater PWM / turntable drive.
module microwave_cook_ctrl
    import microwave_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned N_MODES     = 3,
    parameter int unsigned PWM_PERIOD  = 1000,
    parameter int unsigned ADD_SEC     = 10,
    parameter int unsigned QUICK_SEC   = 30,
    parameter int unsigned MAX_MIN     = 59,
    parameter int unsigned DONE_HOLD_S = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_add,
    input  logic       btn_clr,
    input  logic       btn_start,
    input  logic       btn_mode,
    input  logic       door_open,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [2:0] mode,
    output logic       pwm_out,
    output logic [1:0] motor_dir,
    output logic [3:0] state_led,
    output logic       done
);

    localparam int unsigned PSC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned HOLD_W  = $clog2(DONE_HOLD_S + 1);
    localparam int unsigned DUTY_W  = $clog2(PWM_PERIOD + 1);
    localparam int unsigned TOT_MAX = MAX_MIN * 60 + 59;

    state_e            state_q, state_d;
    logic [5:0]        sec_q, sec_d, min_q, min_d;
    logic [2:0]        mode_q, mode_d;
    logic [PSC_W-1:0]  psc_q, psc_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]        motor_q;
    logic [DUTY_W-1:0] duty;
    logic              tick, any_btn;
    event_e            ev;
    int unsigned       cur, tot, tot_sat;

    // Time is handled as total seconds so add, borrow and saturation share one path.
    always_comb begin
        ev      = pick_event({door_open, btn_clr, btn_start, btn_add, btn_mode});
        any_btn = btn_add | btn_clr | btn_start | btn_mode;
        tick    = (psc_q == PSC_W'(CLK_HZ - 1));
        cur     = 32'(min_q) * 60 + 32'(sec_q);
        tot     = cur;
        state_d = state_q;
        mode_d  = mode_q;
        psc_d   = psc_q;
        hold_d  = hold_q;

        unique case (state_q)
            IDLE: begin
                psc_d  = '0;
                hold_d = '0;
                case (ev)
                    EV_ADD:  tot = cur + ADD_SEC;
                    EV_CLR:  tot = 0;
                    EV_MODE: mode_d = (mode_q == 3'(N_MODES - 1)) ? 3'd0 : mode_q + 3'd1;
                    EV_START: begin
                        if (cur == 0) tot = QUICK_SEC;
                        state_d = RUN;
                    end
                    default: ;
                endcase
            end
            RUN: begin
                if (ev == EV_DOOR || ev == EV_CLR) begin
                    // Prescaler holds here so the fractional second survives the pause.
                    state_d = PAUSE;
                end else begin
                    psc_d = tick ? '0 : psc_q + 1'b1;
                    if (ev == EV_ADD) tot = tot + ADD_SEC;
                    if (tick)         tot = tot - 1;
                    if (tot == 0) begin
                        state_d = DONE;
                        psc_d   = '0;
                        hold_d  = '0;
                    end
                end
            end
            PAUSE: begin
                case (ev)
                    EV_START: state_d = RUN;
                    EV_ADD:   tot = cur + ADD_SEC;
                    EV_CLR: begin
                        state_d = IDLE;
                        tot     = 0;
                    end
                    default: ;
                endcase
            end
            DONE: begin
                tot = 0;
                if (any_btn) begin
                    state_d = IDLE;
                end else begin
                    psc_d = tick ? '0 : psc_q + 1'b1;
                    if (tick) begin
                        if (hold_q == HOLD_W'(DONE_HOLD_S - 1)) state_d = IDLE;
                        else                                   hold_d  = hold_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        tot_sat = (tot > TOT_MAX) ? TOT_MAX : tot;
        min_d   = 6'(tot_sat / 60);
        sec_d   = 6'(tot_sat % 60);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sec_q   <= '0;
            min_q   <= '0;
            mode_q  <= '0;
            psc_q   <= '0;
            hold_q  <= '0;
            motor_q <= 2'b00;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            mode_q  <= mode_d;
            psc_q   <= psc_d;
            hold_q  <= hold_d;
            motor_q <= (state_d == RUN) ? 2'b10 : 2'b00;
        end
    end

    assign duty = DUTY_W'(duty_of(PWM_PERIOD, N_MODES, 32'(mode_q)));

    pwm_gen #(.PWM_PERIOD(PWM_PERIOD)) u_pwm (
        .clk  (clk),
        .rst  (rst),
        .en   (state_d == RUN),
        .duty (duty),
        .pwm  (pwm_out)
    );

    assign sec       = sec_q;
    assign min       = min_q;
    assign mode      = mode_q;
    assign motor_dir = motor_q;
    assign state_led = state_q;
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// Directed bench for microwave_cook_ctrl with a 10-clock second and 10-clock PWM period.
module tb_microwave_cook_ctrl;

    localparam logic [3:0] B_ADD = 4'b0001, B_CLR = 4'b0010, B_START = 4'b0100, B_MODE = 4'b1000;
    localparam int L_IDLE = 1, L_RUN = 2, L_PAUSE = 4, L_DONE = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btns = 4'b0;
    logic       door_open = 1'b0;
    logic [5:0] sec, min;
    logic [2:0] mode;
    logic       pwm_out, done;
    logic [1:0] motor_dir;
    logic [3:0] state_led;

    int n_checks = 0;
    int n_errors = 0;
    int hi;

    microwave_cook_ctrl #(
        .CLK_HZ(10), .N_MODES(3), .PWM_PERIOD(10), .ADD_SEC(10),
        .QUICK_SEC(30), .MAX_MIN(59), .DONE_HOLD_S(3)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_add(btns[0]), .btn_clr(btns[1]), .btn_start(btns[2]), .btn_mode(btns[3]),
        .door_open(door_open),
        .sec(sec), .min(min), .mode(mode), .pwm_out(pwm_out),
        .motor_dir(motor_dir), .state_led(state_led), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] b);
        btns = b;
        step(1);
        btns = 4'b0;
    endtask

    task automatic count_pwm(output int n);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            n += int'(pwm_out);
            step(1);
        end
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        chk("rst_sec", sec, 0);
        chk("rst_min", min, 0);
        chk("rst_mode", mode, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_motor", motor_dir, 0);
        chk("rst_led", state_led, L_IDLE);
        chk("rst_done", done, 0);

        // Basic cook cycle: 0:30, countdown, DONE hold, auto-return.
        repeat (3) press(B_ADD);
        chk("add3_sec", sec, 30);
        press(B_START);
        chk("run_led", state_led, L_RUN);
        chk("run_sec", sec, 30);
        chk("run_motor", motor_dir, 2);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            hi += int'(pwm_out);
            if (i == 9) chk("sec_9clk", sec, 30);
            step(1);
        end
        chk("sec_10clk", sec, 29);
        chk("pwm_mode0", hi, 3);
        step(290);
        chk("end_sec", sec, 0);
        chk("end_min", min, 0);
        chk("done_led", state_led, L_DONE);
        chk("done_flag", done, 1);
        chk("done_motor", motor_dir, 0);
        step(29);
        chk("done_hold", state_led, L_DONE);
        step(1);
        chk("done_exit", state_led, L_IDLE);
        chk("done_clr", done, 0);

        // Quick start, door interlock on start, clr beats start in RUN.
        door_open = 1'b1;
        press(B_START);
        chk("door_start_led", state_led, L_IDLE);
        chk("door_start_sec", sec, 0);
        door_open = 1'b0;
        press(B_START);
        chk("quick_sec", sec, 30);
        chk("quick_led", state_led, L_RUN);
        press(B_CLR | B_START);
        chk("clr_start_led", state_led, L_PAUSE);
        chk("clr_start_sec", sec, 30);
        press(B_CLR);
        chk("pause_clr_led", state_led, L_IDLE);
        chk("pause_clr_sec", sec, 0);

        // Pause at prescaler count 4 keeps the fractional second.
        repeat (2) press(B_ADD);
        press(B_START);
        step(4);
        door_open = 1'b1;
        step(1);
        chk("pause_led", state_led, L_PAUSE);
        chk("pause_pwm", pwm_out, 0);
        chk("pause_motor", motor_dir, 0);
        door_open = 1'b0;
        step(3);
        chk("pause_hold", sec, 20);
        press(B_START);
        chk("resume_led", state_led, L_RUN);
        step(5);
        chk("resume_5", sec, 20);
        step(1);
        chk("resume_6", sec, 19);
        step(70);
        press(B_MODE);
        step(69);
        chk("run_mode_ign", mode, 0);
        chk("at_0_05", sec, 5);
        step(9);
        press(B_ADD);
        chk("tick_add_sec", sec, 14);
        chk("tick_add_min", min, 0);
        chk("tick_add_led", state_led, L_RUN);
        press(B_CLR);
        press(B_CLR);

        // Saturating time entry.
        repeat (359) press(B_ADD);
        chk("add359_min", min, 59);
        chk("add359_sec", sec, 50);
        repeat (41) press(B_ADD);
        chk("sat_min", min, 59);
        chk("sat_sec", sec, 59);
        press(B_CLR);
        chk("clr_min", min, 0);
        chk("clr_sec", sec, 0);

        // Power modes and duty.
        press(B_MODE);
        chk("mode1", mode, 1);
        press(B_ADD);
        press(B_START);
        count_pwm(hi);
        chk("pwm_mode1", hi, 6);
        press(B_CLR);
        press(B_CLR);
        press(B_MODE);
        chk("mode2", mode, 2);
        press(B_START);
        count_pwm(hi);
        chk("pwm_mode2", hi, 10);

        // Reset mid-RUN.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mrst_led", state_led, L_IDLE);
        chk("mrst_sec", sec, 0);
        chk("mrst_min", min, 0);
        chk("mrst_mode", mode, 0);
        chk("mrst_pwm", pwm_out, 0);
        chk("mrst_motor", motor_dir, 0);
        repeat (3) press(B_MODE);
        chk("mode_wrap", mode, 0);
        press(B_ADD);
        press(B_START);
        count_pwm(hi);
        chk("pwm_wrap", hi, 3);
        press(B_CLR);
        press(B_CLR);

        // DONE ignores the door but any button exits early.
        press(B_ADD);
        press(B_START);
        step(100);
        chk("done2_led", state_led, L_DONE);
        door_open = 1'b1;
        step(2);
        chk("done_door", state_led, L_DONE);
        door_open = 1'b0;
        press(B_ADD);
        chk("done_btn_led", state_led, L_IDLE);
        chk("done_btn_sec", sec, 0);
        chk("done_btn_done", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/microwave_cook_ctrl.md
Name: microwave_cook_ctrl

Overview:
Parametrised cook sequencer, the next generation of the microwave controller. It adds N selectable power modes, a door interlock with pause/resume, quick-start, saturating time entry and a timed DONE state. It sits between the btn_debounce instances and the fnd_controller/LED logic. It owns cook time, mode, heater PWM and turntable drive.

Parameters:
CLK_HZ, 100_000_000, clocks per 1 s tick
N_MODES, 3, number of power modes (1..8)
PWM_PERIOD, 1000, heater PWM period in clocks
ADD_SEC, 10, seconds added per btn_add pulse
QUICK_SEC, 30, time loaded by start when time is 0:00
MAX_MIN, 59, saturation limit for minutes (seconds saturate at 59)
DONE_HOLD_S, 3, seconds DONE is held before auto-return to IDLE

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
btn_add  in  1  debounced 1-clk pulse, add ADD_SEC
btn_clr  in  1  debounced pulse, clear/pause
btn_start  in  1  debounced pulse, start/resume
btn_mode  in  1  debounced pulse, next power mode
door_open  in  1  level, 1 = door open
sec  out  6  remaining seconds 0..59
min  out  6  remaining minutes 0..MAX_MIN
mode  out  3  current power mode 0..N_MODES-1
pwm_out  out  1  heater PWM
motor_dir  out  2  turntable drive, 2'b10 = run, 2'b00 = stop
state_led  out  4  one-hot {DONE,PAUSE,RUN,IDLE}
done  out  1  high while in DONE

Behaviour:
- Reset: state IDLE; sec=min=0; mode=0; pwm_out=0; motor_dir=00; state_led=4'b0001; done=0; all counters 0.
- All outputs registered. A button pulse at cycle n is reflected in the outputs at n+1.
- Button priority within one cycle: door_open > btn_clr > btn_start > btn_add > btn_mode. Only the highest-priority active event is acted on; the rest are dropped.
- Time add: sec += ADD_SEC, carrying into min. If the result exceeds MAX_MIN:59, it saturates at MAX_MIN:59.
- Tick prescaler counts 0..CLK_HZ-1 and emits tick at CLK_HZ-1.
  - It is cleared on IDLE->RUN and on entering DONE.
  - It is frozen in PAUSE, so the fractional second is kept across a pause.
  - It counts in RUN and DONE.
- IDLE:
  - btn_add adds time; btn_clr zeroes time; btn_mode advances mode, wrapping N_MODES-1 -> 0.
  - btn_start with door closed: if time != 0, go to RUN; if time == 0, load 0:QUICK_SEC (carry applied) and go to RUN.
  - btn_start with door open is ignored.
- RUN:
  - Each tick decrements time with borrow (m:00 -> (m-1):59).
  - When the decrement reaches 0:00, go to DONE on the same edge.
  - btn_add is allowed. If add and tick coincide, the result is time+ADD_SEC-1, saturated.
  - door_open=1 or btn_clr goes to PAUSE. btn_mode is ignored.
- PAUSE:
  - pwm_out=0, motor_dir=00, time held.
  - btn_start with door closed goes to RUN with no prescaler reset.
  - btn_clr goes to IDLE with time zeroed.
  - btn_add is allowed; btn_mode is ignored.
- DONE:
  - done=1, time=0:00.
  - After DONE_HOLD_S ticks, go to IDLE.
  - Any button pulse goes to IDLE immediately.
  - door_open has no effect.
- PWM:
  - Free-running counter 0..PWM_PERIOD-1.
  - duty(m) = PWM_PERIOD*(m+1)/N_MODES, integer-truncated; the top mode gives 100%.
  - pwm_out = (cnt < duty(mode)) && state==RUN, so the output drops to 0 the cycle after leaving RUN.
  - motor_dir = 2'b10 only in RUN.
- A mode change takes effect at the next PWM compare; no period restart is required.
- rst mid-RUN returns every output to its reset value on the next edge.

Decomposition:
- Package microwave_pkg holds:
  - state enum IDLE/RUN/PAUSE/DONE with one-hot LED encoding
  - the button-priority order constant
  - a duty-table function of (PWM_PERIOD, N_MODES, m)
- Sub-module pwm_gen #(PWM_PERIOD): inputs clk, rst, en, duty; output pwm. It is reusable by the motor controller.
- Time arithmetic (add/saturate/decrement) stays in the top FSM.

Test Plan:
- Use CLK_HZ=10, PWM_PERIOD=10, N_MODES=3. btn_add x3, then btn_start -> min=0, sec=30, state_led=0010. sec reads 29 after 10 clks and 0 after 300 clks. DONE is held for 30 clks, then state_led=0001.
- btn_start at 0:00 with door closed -> 0:30 and RUN. The same with door_open=1 -> stays IDLE at 0:00.
- In RUN at 0:20, assert door_open at prescaler count 4 -> PAUSE, pwm_out=0 next cycle. Release door, btn_start -> sec becomes 19 exactly 6 clks later.
- btn_add x400 in IDLE with MAX_MIN=59 -> saturates at 59:59. btn_clr -> 0:00.
- btn_mode x1 then RUN -> pwm high 6 of every 10 clks. btn_mode x3 from reset -> mode wraps to 0, pwm high 3 of 10.
- btn_clr and btn_start in the same cycle in RUN -> PAUSE, not resume. Tick and btn_add together at 0:05 -> 0:14.
